// File: rtl/frame_addr_gen_if.sv
// Handshake/bus bundle for the raster address generator: scan control and
// window inputs in one direction, pixel address/coordinates and strobes back.
interface frame_addr_gen_if #(
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter int ADDR_W = 16
);
  logic              start;
  logic              stop;
  logic              enable;
  logic              mode;
  logic [X_W-1:0]    win_x0;
  logic [Y_W-1:0]    win_y0;
  logic [X_W:0]      win_w;
  logic [Y_W:0]      win_h;

  logic [ADDR_W-1:0] addr;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic              valid;
  logic              busy;
  logic              line_end;
  logic              frame_done;
  logic              err;

  modport master (
    output start, stop, enable, mode, win_x0, win_y0, win_w, win_h,
    input  addr, x, y, valid, busy, line_end, frame_done, err
  );

  modport slave (
    input  start, stop, enable, mode, win_x0, win_y0, win_w, win_h,
    output addr, x, y, valid, busy, line_end, frame_done, err
  );
endinterface

// File: rtl/frame_addr_gen.sv
// Raster address generator: walks a full frame or a rectangular window in
// row-major order, one pixel per enabled cycle, one-shot or free-running.
module frame_addr_gen #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 180,
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter int ADDR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  frame_addr_gen_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [X_W+1:0]    H_LIM  = (X_W+2)'(H_RES);
  localparam logic [Y_W+1:0]    V_LIM  = (Y_W+2)'(V_RES);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic              valid_q;
  logic              busy_q;
  logic              frame_done_q;
  logic              err_q;

  // Window latched at start; stored as first/last coordinates so the pixel
  // loop only needs equality compares.
  logic [X_W-1:0]    x0_q;
  logic [X_W-1:0]    x_last_q;
  logic [Y_W-1:0]    y0_q;
  logic [Y_W-1:0]    y_last_q;
  logic [ADDR_W-1:0] first_addr_q;
  logic              mode_q;

  logic              full_sel;
  logic [X_W-1:0]    s_x0;
  logic [Y_W-1:0]    s_y0;
  logic [X_W:0]      s_w;
  logic [Y_W:0]      s_h;
  logic [X_W+1:0]    x_end;
  logic [Y_W+1:0]    y_end;
  logic              win_ok;
  logic [ADDR_W-1:0] first_addr_c;
  logic              at_last_col;
  logic              at_last_row;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    full_sel     = 1'b0;
    s_x0         = bus.win_x0;
    s_y0         = bus.win_y0;
    s_w          = bus.win_w;
    s_h          = bus.win_h;
    if ((bus.win_w == '0) || (bus.win_h == '0)) begin
      full_sel = 1'b1;
      s_x0     = '0;
      s_y0     = '0;
      s_w      = (X_W+1)'(H_RES);
      s_h      = (Y_W+1)'(V_RES);
    end
    x_end        = {2'b00, s_x0} + {1'b0, s_w};
    y_end        = {2'b00, s_y0} + {1'b0, s_h};
    win_ok       = (x_end <= H_LIM) && (y_end <= V_LIM);
    // The only multiply; H_RES is constant so this maps to shift-and-add.
    first_addr_c = ADDR_W'(s_y0) * H_STEP + ADDR_W'(s_x0);
  end

  assign at_last_col = (x_q == x_last_q);
  assign at_last_row = (y_q == y_last_q);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      row_base_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      // NOTE: the latched window resets to the full frame so line_end and the
      // wrap target are well defined even before the first start.
      x0_q         <= '0;
      x_last_q     <= X_W'(H_RES - 1);
      y0_q         <= '0;
      y_last_q     <= Y_W'(V_RES - 1);
      first_addr_q <= '0;
      mode_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (!win_ok) begin
              err_q <= 1'b1;
            end else begin
              x0_q         <= s_x0;
              x_last_q     <= X_W'(x_end - (X_W+2)'(1));
              y0_q         <= s_y0;
              y_last_q     <= Y_W'(y_end - (Y_W+2)'(1));
              first_addr_q <= first_addr_c;
              mode_q       <= bus.mode;
              addr_q       <= first_addr_c;
              row_base_q   <= first_addr_c;
              x_q          <= s_x0;
              y_q          <= s_y0;
              valid_q      <= 1'b1;
              busy_q       <= 1'b1;
              state        <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else if (bus.enable) begin
            if (!at_last_col) begin
              x_q    <= x_q + X_W'(1);
              addr_q <= addr_q + ADDR_W'(1);
            end else if (!at_last_row) begin
              x_q        <= x0_q;
              y_q        <= y_q + Y_W'(1);
              addr_q     <= row_base_q + H_STEP;
              row_base_q <= row_base_q + H_STEP;
            end else begin
              frame_done_q <= 1'b1;
              if (!mode_q) begin
                // Free-running: reload the first window pixel with no gap.
                x_q        <= x0_q;
                y_q        <= y0_q;
                addr_q     <= first_addr_q;
                row_base_q <= first_addr_q;
              end else begin
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                state   <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.addr       = addr_q;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = busy_q;
  assign bus.line_end   = valid_q && at_last_col;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;

  // full_sel is kept for readability of the selection above.
  logic unused_ok;
  assign unused_ok = full_sel;

endmodule

// File: tb/tb_frame_addr_gen.sv
// Self-checking bench for frame_addr_gen: directed scenarios plus a random
// phase, all compared cycle by cycle against a pixel-index reference model.
module tb_frame_addr_gen;

  localparam int H_RES  = 320;
  localparam int V_RES  = 180;
  localparam int X_W    = 9;
  localparam int Y_W    = 8;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  frame_addr_gen_if #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) bus();

  frame_addr_gen #(
    .H_RES(H_RES), .V_RES(V_RES), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: the scan is a pixel index k over a w*h window;
  // coordinates and address follow from k with plain arithmetic.
  bit m_run, m_valid, m_busy, m_fd, m_err, m_mode;
  int m_k, m_x0, m_y0, m_w, m_h, m_x, m_y, m_addr;

  function automatic void model_pixel();
    m_x    = m_x0 + (m_k % m_w);
    m_y    = m_y0 + (m_k / m_w);
    m_addr = m_y * H_RES + m_x;
  endfunction

  function automatic void model_update();
    int x0, y0, w, h;
    if (reset) begin
      m_run = 0; m_valid = 0; m_busy = 0; m_fd = 0; m_err = 0; m_mode = 0;
      m_k = 0; m_x0 = 0; m_y0 = 0; m_w = H_RES; m_h = V_RES;
      m_x = 0; m_y = 0; m_addr = 0;
      return;
    end
    m_fd  = 0;
    m_err = 0;
    if (!m_run) begin
      if (bus.start) begin
        x0 = int'(bus.win_x0); y0 = int'(bus.win_y0);
        w  = int'(bus.win_w);  h  = int'(bus.win_h);
        if (w == 0 || h == 0) begin
          x0 = 0; y0 = 0; w = H_RES; h = V_RES;
        end
        if (x0 + w > H_RES || y0 + h > V_RES) begin
          m_err = 1;
        end else begin
          m_x0 = x0; m_y0 = y0; m_w = w; m_h = h; m_mode = bus.mode;
          m_run = 1; m_valid = 1; m_busy = 1; m_k = 0;
          model_pixel();
        end
      end
    end else if (bus.stop) begin
      m_run = 0; m_valid = 0; m_busy = 0;
    end else if (bus.enable) begin
      if (m_k == m_w * m_h - 1) begin
        m_fd = 1;
        if (!m_mode) begin
          m_k = 0;
          model_pixel();
        end else begin
          m_run = 0; m_valid = 0; m_busy = 0;
        end
      end else begin
        m_k++;
        model_pixel();
      end
    end
  endfunction

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("addr",       bus.addr,       m_addr);
    check("x",          bus.x,          m_x);
    check("y",          bus.y,          m_y);
    check("valid",      bus.valid,      m_valid);
    check("busy",       bus.busy,       m_busy);
    check("line_end",   bus.line_end,   m_valid && (m_x == m_x0 + m_w - 1));
    check("frame_done", bus.frame_done, m_fd);
    check("err",        bus.err,        m_err);
  endtask

  task automatic scramble_window();
    bus.win_x0 = X_W'($urandom);
    bus.win_y0 = Y_W'($urandom);
    bus.win_w  = (X_W+1)'($urandom);
    bus.win_h  = (Y_W+1)'($urandom);
  endtask

  task automatic start_scan(input int x0, input int y0, input int w, input int h, input bit md);
    bus.win_x0 = X_W'(x0);
    bus.win_y0 = Y_W'(y0);
    bus.win_w  = (X_W+1)'(w);
    bus.win_h  = (Y_W+1)'(h);
    bus.mode   = md;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    scramble_window();
    bus.mode   = ~md;
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 70000 && !(m_valid && m_addr == target); i++) step();
    check("reach_addr", bus.addr, target);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int exp_seq[6] = '{1610, 1611, 1612, 1930, 1931, 1932};
  bit exp_le[6]  = '{0, 0, 1, 0, 0, 1};
  int fd_count;

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.stop = 0; bus.enable = 0; bus.mode = 0;
    scramble_window();
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    check("rst_addr",  bus.addr,  0);
    check("rst_valid", bus.valid, 0);
    check("rst_busy",  bus.busy,  0);

    // Full frame, continuous: 57600 consecutive addresses, then wrap to 0.
    bus.enable = 1;
    start_scan(0, 0, 0, 0, 1'b0);
    check("ff_first_valid", bus.valid, 1);
    check("ff_first_addr",  bus.addr,  0);
    for (int i = 0; i < 57599; i++) step();
    check("ff_last_addr", bus.addr, 57599);
    check("ff_last_le",   bus.line_end, 1);
    step();
    check("ff_wrap_addr",  bus.addr,       0);
    check("ff_wrap_valid", bus.valid,      1);
    check("ff_wrap_fd",    bus.frame_done, 1);
    step();
    check("ff_fd_pulse", bus.frame_done, 0);
    bus.stop = 1; step(); bus.stop = 0;

    // Bottom-right corner window, continuous: two wraps ending at 57599.
    start_scan(300, 170, 20, 10, 1'b0);
    fd_count = 0;
    for (int i = 0; i < 402; i++) begin
      step();
      if (bus.frame_done) fd_count++;
    end
    check("corner_wraps", fd_count, 2);
    bus.stop = 1; step(); bus.stop = 0;
    check("stop_no_fd", bus.frame_done, 0);

    // Same corner, one-shot: ends idle holding the last pixel 57599.
    start_scan(300, 170, 20, 10, 1'b1);
    for (int i = 0; i < 200; i++) step();
    check("os_fd",    bus.frame_done, 1);
    check("os_valid", bus.valid, 0);
    check("os_busy",  bus.busy, 0);
    check("os_hold",  bus.addr, 57599);

    // Small one-shot window.
    begin
      int got[$];
      bit le[$];
      start_scan(10, 5, 3, 2, 1'b1);
      for (int i = 0; i < 6; i++) begin
        got.push_back(int'(bus.addr));
        le.push_back(bus.line_end);
        step();
      end
      for (int i = 0; i < 6; i++) begin
        check("win_addr", got[i], exp_seq[i]);
        check("win_le",   le[i],  exp_le[i]);
      end
      check("win_fd", bus.frame_done, 1);
    end

    // Out-of-range window rejected, then w = h = 0 forces full frame.
    start_scan(318, 0, 3, 1, 1'b1);
    check("rej_err",   bus.err,   1);
    check("rej_busy",  bus.busy,  0);
    check("rej_valid", bus.valid, 0);
    step();
    check("rej_err_pulse", bus.err, 0);
    start_scan(123, 7, 0, 0, 1'b1);
    check("full_sel_addr", bus.addr, 0);
    bus.stop = 1; step(); bus.stop = 0;

    // Mid-scan controls: enable hold, start while busy, stop beats enable.
    start_scan(0, 0, 0, 0, 1'b1);
    run_until(100);
    bus.enable = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_addr", bus.addr, 100);
    end
    bus.enable = 1;
    run_until(150);
    start_scan(10, 5, 3, 2, 1'b1);
    check("start_busy_ignored", bus.addr, 151);
    run_until(200);
    bus.stop = 1; step(); bus.stop = 0;
    check("stop_valid", bus.valid, 0);
    check("stop_busy",  bus.busy, 0);
    check("stop_fd",    bus.frame_done, 0);

    // Reset mid-scan, then a 1x1 one-shot window.
    start_scan(0, 0, 0, 0, 1'b0);
    run_until(3000);
    do_reset();
    check("mid_rst_addr",  bus.addr,  0);
    check("mid_rst_valid", bus.valid, 0);
    check("mid_rst_busy",  bus.busy,  0);
    start_scan(0, 0, 1, 1, 1'b1);
    check("px1_valid", bus.valid, 1);
    check("px1_le",    bus.line_end, 1);
    step();
    check("px1_fd",    bus.frame_done, 1);
    check("px1_addr",  bus.addr, 0);
    check("px1_idle",  bus.busy, 0);

    // Random phase: small windows (some at or past the edges), random
    // enable/stop/start/reset and window inputs left changing when idle.
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      bus.enable = ($urandom_range(0, 3) != 0);
      bus.stop   = ($urandom_range(0, 39) == 0);
      bus.start  = ($urandom_range(0, 5) == 0);
      bus.mode   = 1'($urandom);
      bus.win_w  = (X_W+1)'($urandom_range(0, 6));
      bus.win_h  = (Y_W+1)'($urandom_range(0, 4));
      if ($urandom_range(0, 1) == 0) begin
        bus.win_x0 = X_W'(H_RES - int'(bus.win_w) + $urandom_range(0, 1));
        bus.win_y0 = Y_W'(V_RES - int'(bus.win_h) + $urandom_range(0, 1));
      end else begin
        bus.win_x0 = X_W'($urandom_range(0, H_RES - 1));
        bus.win_y0 = Y_W'($urandom_range(0, V_RES - 1));
      end
      if (bus.win_w == '0 || bus.win_h == '0) bus.stop = ($urandom_range(0, 3) == 0);
      step();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
